// File: rtl/fir_seq_ctrl.sv
// FIR burst sequencer: coefficient addressing, accumulator control and result strobe.
// Optional sticky burst-error flag built only when FIR_SEQ_ERR_EN is defined.
module fir_seq_ctrl #(
    parameter int NUM_TAPS = 1021,
    parameter int PIPE_DLY = 2,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sequencing,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              clr_acc,
    output logic              acc_en,
    output logic              out_vld,
    output logic              busy,
    output logic              err
);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    tap_cnt;
    logic [PIPE_DLY-1:0] vld_pipe;
    logic [PIPE_DLY-1:0] clr_pipe;
    logic                take, tap_acc, first_tap, burst_end;

    // A sample is taken in IDLE/RUN, but only the first NUM_TAPS reach the accumulator.
    assign take      = sequencing && (state == IDLE || state == RUN);
    assign tap_acc   = take && (tap_cnt < CNT_W'(NUM_TAPS));
    assign first_tap = tap_acc && (tap_cnt == '0);
    assign burst_end = (state == RUN) && !sequencing;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sequencing)       state_nxt = RUN;
            RUN:     if (!sequencing)      state_nxt = DRAIN;
            DRAIN:   if (vld_pipe == '0)   state_nxt = DONE;
            DONE:                          state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt   <= '0;
            coef_addr <= '0;
            vld_pipe  <= '0;
            clr_pipe  <= '0;
        end else begin
            if (burst_end) begin
                tap_cnt   <= '0;
                coef_addr <= '0;
            end else if (take) begin
                // Count saturates one past NUM_TAPS so an overlong burst stays detectable.
                if (tap_cnt != CNT_W'(NUM_TAPS + 1))   tap_cnt   <= tap_cnt + 1'b1;
                if (coef_addr != ADDR_W'(NUM_TAPS - 1)) coef_addr <= coef_addr + 1'b1;
            end
            vld_pipe[0] <= tap_acc;
            clr_pipe[0] <= first_tap;
            for (int i = 1; i < PIPE_DLY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                clr_pipe[i] <= clr_pipe[i-1];
            end
        end
    end

    assign acc_en  = vld_pipe[PIPE_DLY-1];
    assign clr_acc = clr_pipe[PIPE_DLY-1];
    assign out_vld = (state == DONE);
    assign busy    = (state != IDLE);

`ifdef FIR_SEQ_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if ((burst_end && tap_cnt != CNT_W'(NUM_TAPS)) ||
                 (sequencing && (state == DRAIN || state == DONE)))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
